// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives the byte-addressed data SRAM, extracts and
// extends load data, and holds the MEM/WB pipeline register plus event counters.
module mem_access_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ALIGN_CHECK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_store_data,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              wb_fault,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt,
  output logic [31:0]       fault_cnt
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  logic        illegal_f3;
  logic        misalign;
  logic        fault;
  logic        advance;
  logic        live;
  logic [3:0]  st_mask;
  logic [31:0] load_data;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic        wb_reg_write_q;
  logic [31:0] wb_data_q;
  logic        wb_fault_q;
  logic [31:0] load_cnt_q;
  logic [31:0] store_cnt_q;
  logic [31:0] fault_cnt_q;

  // Upper address bits are beyond the SRAM and deliberately ignored.
  if (ADDR_W < 32) begin : g_addr_unused
    logic unused_addr;
    assign unused_addr = ^ex_addr[31:ADDR_W];
  end

  assign sram_address = ex_addr[ADDR_W-1:0];
  assign sram_wdata   = ex_store_data;

  // Decode access size: store byte mask, funct3 legality and alignment.
  always_comb begin
    st_mask    = 4'b0000;
    illegal_f3 = 1'b0;
    misalign   = 1'b0;
    case (ex_funct3)
      F3B: st_mask = 4'b0001;
      F3H: begin
        st_mask  = 4'b0011;
        misalign = ex_addr[0];
      end
      F3W: begin
        st_mask  = 4'b1111;
        misalign = |ex_addr[1:0];
      end
      F3BU: illegal_f3 = ex_mem_write;
      F3HU: begin
        illegal_f3 = ex_mem_write;
        misalign   = ex_addr[0];
      end
      default: illegal_f3 = 1'b1;
    endcase
    if (ALIGN_CHECK == 0) misalign = 1'b0;
  end

  assign fault = ex_valid & (ex_mem_read | ex_mem_write) &
                 (illegal_f3 | (ex_mem_read & ex_mem_write) | misalign);

  // A faulted, stalled or flushed store must never reach the SRAM.
  assign sram_w_en = (ex_valid & ex_mem_write & ~stall & ~flush & ~fault) ? st_mask : 4'b0000;

  // Extract the addressed bytes from the low end of the read word and extend.
  always_comb begin
    load_data = sram_rdata;
    case (ex_funct3)
      F3B:     load_data = {{24{sram_rdata[7]}}, sram_rdata[7:0]};
      F3H:     load_data = {{16{sram_rdata[15]}}, sram_rdata[15:0]};
      F3BU:    load_data = {24'd0, sram_rdata[7:0]};
      F3HU:    load_data = {16'd0, sram_rdata[15:0]};
      default: load_data = sram_rdata;
    endcase
  end

  assign advance = ~stall;
  assign live    = ex_valid & ~flush;

  // MEM/WB register and event counters; everything holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= 32'd0;
      wb_fault_q     <= 1'b0;
      load_cnt_q     <= 32'd0;
      store_cnt_q    <= 32'd0;
      fault_cnt_q    <= 32'd0;
    end else if (advance) begin
      wb_valid_q     <= live;
      wb_rd_q        <= ex_rd;
      wb_reg_write_q <= live & ex_reg_write & ~fault;
      wb_data_q      <= ex_mem_read ? load_data : ex_alu_result;
      wb_fault_q     <= fault & ~flush;
      if (live) begin
        if (fault) begin
          fault_cnt_q <= fault_cnt_q + 32'd1;
        end else if (ex_mem_read) begin
          load_cnt_q <= load_cnt_q + 32'd1;
        end else if (ex_mem_write) begin
          store_cnt_q <= store_cnt_q + 32'd1;
        end
      end
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign wb_fault     = wb_fault_q;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array SRAM, a byte-level reference model
// checked every negedge, and directed vectors with literal expectations.
module tb_mem_access_unit;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, stall, flush;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_store_data, ex_alu_result;
  logic [4:0]  ex_rd;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_wdata, sram_rdata;
  logic        wb_valid, wb_reg_write, wb_fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, load_cnt, store_cnt, fault_cnt;

  // Second instance without alignment checking, observed only for the misaligned case.
  logic [3:0]  d0_w_en;
  logic [15:0] d0_address;
  logic [31:0] d0_wdata, d0_wb_data, d0_load_cnt, d0_store_cnt, d0_fault_cnt;
  logic        d0_wb_valid, d0_wb_reg_write, d0_wb_fault;
  logic [4:0]  d0_wb_rd;

  logic [7:0] sram_mem [0:65535] = '{default: 8'h00};
  logic [7:0] ref_mem  [0:65535] = '{default: 8'h00};

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(16), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .stall(stall), .flush(flush), .sram_w_en(sram_w_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .wb_fault(wb_fault), .load_cnt(load_cnt), .store_cnt(store_cnt), .fault_cnt(fault_cnt)
  );

  mem_access_unit #(.ADDR_W(16), .ALIGN_CHECK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .stall(stall), .flush(flush), .sram_w_en(d0_w_en),
    .sram_address(d0_address), .sram_wdata(d0_wdata), .sram_rdata(sram_rdata),
    .wb_valid(d0_wb_valid), .wb_rd(d0_wb_rd), .wb_reg_write(d0_wb_reg_write),
    .wb_data(d0_wb_data), .wb_fault(d0_wb_fault), .load_cnt(d0_load_cnt),
    .store_cnt(d0_store_cnt), .fault_cnt(d0_fault_cnt)
  );

  // SRAM environment: combinational little-endian read, byte-masked write on the edge.
  assign sram_rdata = {sram_mem[sram_address + 16'd3], sram_mem[sram_address + 16'd2],
                       sram_mem[sram_address + 16'd1], sram_mem[sram_address]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (sram_w_en[k]) sram_mem[sram_address + 16'(k)] <= sram_wdata[8*k +: 8];
  end

  function automatic logic [31:0] sram_word(input logic [15:0] a);
    return {sram_mem[a + 16'd3], sram_mem[a + 16'd2], sram_mem[a + 16'd1], sram_mem[a]};
  endfunction

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_fault_of(input logic v, rd, wr, input logic [2:0] f3,
                                    input logic [31:0] a);
    bit legal, mis;
    int n;
    n     = acc_bytes(f3);
    legal = wr ? (f3 == B || f3 == H || f3 == W)
               : (f3 == B || f3 == H || f3 == W || f3 == BU || f3 == HU);
    mis   = (n > 1) && ((a % n) != 0);
    return v && (rd || wr) && (!legal || (rd && wr) || mis);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] val;
    int n;
    n   = acc_bytes(f3);
    val = 32'd0;
    for (int k = 0; k < n; k++) val = val | (32'(ref_mem[a[15:0] + 16'(k)]) << (8 * k));
    if (!f3[2] && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && val[15]) val = val | 32'hFFFF_0000;
    return val;
  endfunction

  function automatic logic [3:0] m_wen();
    bit f;
    f = m_fault_of(ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr);
    if (ex_valid && ex_mem_write && !stall && !flush && !f)
      return 4'((1 << acc_bytes(ex_funct3)) - 1);
    return 4'b0000;
  endfunction

  logic        m_valid, m_regw, m_flt, m_data_chk;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_lc, m_sc, m_fc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_regw <= 1'b0; m_flt <= 1'b0; m_rd <= 5'd0;
      m_data <= 32'd0; m_data_chk <= 1'b1; m_lc <= 32'd0; m_sc <= 32'd0; m_fc <= 32'd0;
    end else if (!stall) begin
      m_valid    <= ex_valid && !flush;
      m_rd       <= ex_rd;
      m_flt      <= m_fault_of(ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr) && !flush;
      m_regw     <= ex_valid && !flush && ex_reg_write &&
                    !m_fault_of(ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr);
      m_data     <= ex_mem_read ? m_load(ex_funct3, ex_addr) : ex_alu_result;
      m_data_chk <= !(ex_mem_read &&
                      m_fault_of(ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr));
      if (ex_valid && !flush) begin
        if (m_fault_of(ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_addr)) m_fc <= m_fc + 1;
        else if (ex_mem_read)  m_lc <= m_lc + 1;
        else if (ex_mem_write) m_sc <= m_sc + 1;
      end
      for (int k = 0; k < 4; k++)
        if (m_wen()[k]) ref_mem[ex_addr[15:0] + 16'(k)] <= ex_store_data[8*k +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      check("sram_w_en", 32'(sram_w_en), 32'(m_wen()));
      check("sram_address", 32'(sram_address), 32'(ex_addr[15:0]));
      check("sram_wdata", sram_wdata, ex_store_data);
      check("wb_valid", 32'(wb_valid), 32'(m_valid));
      check("wb_rd", 32'(wb_rd), 32'(m_rd));
      check("wb_reg_write", 32'(wb_reg_write), 32'(m_regw));
      check("wb_fault", 32'(wb_fault), 32'(m_flt));
      if (m_data_chk) check("wb_data", wb_data, m_data);
      check("load_cnt", load_cnt, m_lc);
      check("store_cnt", store_cnt, m_sc);
      check("fault_cnt", fault_cnt, m_fc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_op(input logic v, rd, wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] alu, input logic [4:0] rdi,
                        input logic rw);
    ex_valid = v; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_addr = a;
    ex_store_data = sd; ex_alu_result = alu; ex_rd = rdi; ex_reg_write = rw;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
    check({tag, " wb_reg_write"}, 32'(wb_reg_write), 32'd0);
    check({tag, " wb_data"}, wb_data, 32'd0);
    check({tag, " wb_fault"}, 32'(wb_fault), 32'd0);
    check({tag, " counters"}, load_cnt | store_cnt | fault_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_op(0, 0, 0, B, 0, 0, 0, 0, 0);
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();
    run_chk = 1'b1;

    // 1: SW then LW of the same word on the next cycle
    set_op(1, 0, 1, W, 32'h10, 32'hDEAD_BEEF, 32'h1234, 5'd0, 1'b0);
    #1 check("t1 w_en", 32'(sram_w_en), 32'hF);
    tick();
    set_op(1, 1, 0, W, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    check("t1 wb_data", wb_data, 32'hDEAD_BEEF);
    check("t1 wb_rd", 32'(wb_rd), 32'd5);
    check("t1 store_cnt", store_cnt, 32'd1);
    check("t1 load_cnt", load_cnt, 32'd1);

    // 2: byte store, signed/unsigned byte loads, word read shows one byte written
    set_op(1, 0, 1, B, 32'h21, 32'hABCD_EF80, 32'h0, 5'd0, 1'b0);
    #1 check("t2 w_en", 32'(sram_w_en), 32'h1);
    tick();
    set_op(1, 1, 0, B, 32'h21, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    check("t2 LB", wb_data, 32'hFFFF_FF80);
    set_op(1, 1, 0, BU, 32'h21, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    check("t2 LBU", wb_data, 32'h0000_0080);
    set_op(1, 1, 0, W, 32'h20, 32'h0, 32'h0, 5'd6, 1'b1);
    tick();
    check("t2 LW", wb_data, 32'h0000_8000);

    // 3: half store and loads
    set_op(1, 0, 1, H, 32'h30, 32'h1234_8001, 32'h0, 5'd0, 1'b0);
    #1 check("t3 w_en", 32'(sram_w_en), 32'h3);
    tick();
    set_op(1, 1, 0, H, 32'h30, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    check("t3 LH", wb_data, 32'hFFFF_8001);
    set_op(1, 1, 0, HU, 32'h30, 32'h0, 32'h0, 5'd8, 1'b1);
    tick();
    check("t3 LHU", wb_data, 32'h0000_8001);
    set_op(1, 0, 0, W, 32'h30, 32'h0, 32'h55AA, 5'd7, 1'b1);
    tick();
    check("alu wb_data", wb_data, 32'h0000_55AA);
    check("alu wb_reg_write", 32'(wb_reg_write), 32'd1);

    // 4: misaligned word store faults with alignment checking on
    set_op(1, 0, 1, W, 32'h40, 32'h1122_3344, 32'h0, 5'd0, 1'b0);
    tick();
    set_op(1, 0, 1, W, 32'h44, 32'h5566_7788, 32'h0, 5'd0, 1'b0);
    tick();
    set_op(1, 0, 1, W, 32'h42, 32'h9999_9999, 32'h0, 5'd9, 1'b1);
    #1 check("t4 w_en", 32'(sram_w_en), 32'h0);
    check("t4 noalign w_en", 32'(d0_w_en), 32'hF);
    tick();
    check("t4 wb_fault", 32'(wb_fault), 32'd1);
    check("t4 wb_valid", 32'(wb_valid), 32'd1);
    check("t4 wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("t4 fault_cnt", fault_cnt, 32'd1);
    check("t4 noalign wb_fault", 32'(d0_wb_fault), 32'd0);
    check("t4 memory", sram_word(16'h42), 32'h7788_1122);
    set_op(1, 1, 0, W, 32'h40, 32'h0, 32'h0, 5'd3, 1'b1);
    tick();
    check("t4 LW", wb_data, 32'h1122_3344);
    set_op(1, 0, 1, BU, 32'h50, 32'hFF, 32'h0, 5'd0, 1'b0);  // illegal store width
    tick();
    set_op(1, 1, 1, W, 32'h50, 32'hFF, 32'h0, 5'd4, 1'b1);   // read and write together
    tick();
    set_op(1, 1, 0, H, 32'h31, 32'h0, 32'h0, 5'd4, 1'b1);    // misaligned half load
    tick();
    check("t4 fault_cnt total", fault_cnt, 32'd4);
    check("t4 load reg_write", 32'(wb_reg_write), 32'd0);

    // 5: store held three cycles under stall, written once on release
    set_op(1, 0, 1, W, 32'h50, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t5 stalled w_en", 32'(sram_w_en), 32'h0);
      tick();
      check("t5 stalled mem", sram_word(16'h50), 32'h0);
      check("t5 stalled store_cnt", store_cnt, 32'd5);
    end
    stall = 1'b0;
    #1 check("t5 release w_en", 32'(sram_w_en), 32'hF);
    tick();
    check("t5 store_cnt", store_cnt, 32'd6);
    check("t5 mem", sram_word(16'h50), 32'hCAFE_F00D);

    // 6: flushed store, then stall together with flush
    set_op(1, 0, 1, W, 32'h60, 32'h1234_5678, 32'h0, 5'd0, 1'b0);
    flush = 1'b1;
    #1 check("t6 flush w_en", 32'(sram_w_en), 32'h0);
    tick();
    check("t6 wb_valid", 32'(wb_valid), 32'd0);
    check("t6 mem", sram_word(16'h60), 32'h0);
    set_op(1, 0, 0, W, 32'h0, 32'h0, 32'h77, 5'd2, 1'b1);
    tick();
    set_op(1, 0, 1, W, 32'h64, 32'h8765_4321, 32'h0, 5'd0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    #1 check("t6 stall+flush w_en", 32'(sram_w_en), 32'h0);
    tick();
    check("t6 stall+flush hold", 32'(wb_valid), 32'd1);
    check("t6 stall+flush data", wb_data, 32'h77);
    check("t6 stall+flush mem", sram_word(16'h64), 32'h0);

    // Asynchronous reset in the middle of a pending store
    set_op(1, 0, 1, W, 32'h70, 32'hA5A5_A5A5, 32'h0, 5'd1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    set_op(0, 0, 0, B, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    set_op(1, 1, 0, W, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1);
    tick();
    check("post-reset LW", wb_data, 32'hDEAD_BEEF);
    check("post-reset load_cnt", load_cnt, 32'd1);
    check("post-reset mem", sram_word(16'h70), 32'h0);
    set_op(0, 0, 0, B, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
